data_mem_stage: RTL and testbench
=================================

# data_mem_stage

Parametrised memory stage of the MIPS pipeline, between execute and write-back. It accepts one execute-stage transaction per cycle over a valid/ready handshake and performs the load, store or pass-through it encodes against an internal single-port synchronous data RAM. It presents one registered result per transaction with one cycle of latency, and stalls cleanly under back-pressure. It also flags out-of-range addresses and keeps saturating load/store counters for debug.

## Interface
- DATA_W, 8, data and ALU-result width
- ADDR_W, 8, address bits taken from the low bits of ans_ex (ADDR_W ≤ DATA_W)
- DEPTH, 256, RAM words (1 ≤ DEPTH ≤ 2^ADDR_W)
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  execute-stage transaction present
- in_ready  out  1  stage can accept this cycle
- ans_ex  in  DATA_W  ALU result; low ADDR_W bits are the memory address
- dm_data  in  DATA_W  store data
- mem_en_ex  in  1  memory access enable
- mem_rw_ex  in  1  1 = write, 0 = read (when mem_en_ex = 1)
- mem_mux_sel  in  1  1 = result is memory data, 0 = result is ans_ex
- out_valid  out  1  ans_dm holds a valid result
- out_ready  in  1  write-back consumes the result
- ans_dm  out  DATA_W  stage result
- addr_err  out  1  result's transaction addressed ≥ DEPTH with mem_en_ex = 1
- load_cnt  out  CNT_W  accepted in-range reads, saturating
- store_cnt  out  CNT_W  accepted in-range writes, saturating

## Operation
- Accept = in_valid & in_ready.
- in_ready = !out_valid | out_ready. The stage has a single output slot and no skid buffer.
- On accept, the operation class is decided:
  - STORE: mem_en_ex & mem_rw_ex.
  - LOAD: mem_en_ex & !mem_rw_ex.
  - PASS: otherwise.
- In range: address < DEPTH.
- STORE, in range: RAM[addr] ← dm_data; store_cnt increments.
- STORE, out of range: the write is suppressed; addr_err is set for this result.
- LOAD, in range: RAM is read; load_cnt increments.
- LOAD, out of range: read data is 0; addr_err is set.
- The RAM is write-first: a STORE presents dm_data as its read data.
- ans_dm = memory data if mem_mux_sel & mem_en_ex, else ans_ex. The select is captured on accept.
- Counters hold at all-ones; they never wrap.
- No accept means no RAM access and no counter change. Output registers hold while out_valid & !out_ready.
- out_valid next-state:
  - Set on accept.
  - Cleared on out_ready with no accept.
  - Remains 1 when consuming and accepting in the same cycle.

## Timing
- Latency: accept at edge N → ans_dm/out_valid/addr_err valid after edge N; consumed no earlier than edge N+1.
- Throughput: 1 transaction/cycle while out_ready = 1.
- Back-to-back STORE then LOAD to the same address returns the stored value; no hazard bubble.
- All outputs are registered; in_ready is combinational from out_valid and out_ready only.
- Reset asserted (asynchronous):
  - out_valid = 0, ans_dm = 0, addr_err = 0, load_cnt = 0, store_cnt = 0.
  - No RAM write while reset is high; RAM contents are not cleared.
  - A pending result is dropped.
- in_ready = 1 during reset (out_valid = 0), but transactions presented while reset is high are ignored.

## Structure
- Package data_mem_pkg holds the op-class enum (OP_PASS, OP_LOAD, OP_STORE) and the classification function.
- Sub-module dm_ram: single-port synchronous write-first RAM, parameters DATA_W and DEPTH, inferred (no vendor core), read data registered, read enable gated by accept.
- Top holds the handshake, capture registers, range check, result mux and counters.

## Test plan
- Reset: assert reset mid-cycle → all outputs 0 immediately, in_ready = 1 after release.
- Store 0x5A at 0x10, next cycle load 0x10 with mem_mux_sel = 1 → ans_dm = 0x5A one cycle after the load accept; store_cnt = 1, load_cnt = 1.
- Pass-through: mem_en_ex = 0, ans_ex = 0x33 → ans_dm = 0x33, counters unchanged, no RAM change.
- Stall: out_ready = 0 with a result pending → in_ready = 0, ans_dm stable for 3 cycles. Raise out_ready with a new load in flight → consume and accept in the same cycle, out_valid stays 1.
- DEPTH = 200: store 0xFF at address 0xC8 → addr_err = 1, store_cnt unchanged. Load 0xC8 → ans_dm = 0, addr_err = 1. Load 0xC7 → addr_err = 0.
- CNT_W = 2: issue 5 loads → load_cnt saturates at 3. Reset during a stalled result → out_valid drops at once, and a later load of 0x10 still returns 0x5A.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types for the MIPS memory stage: operation classes and the decode
// from the execute-stage enable/read-write pair.
package data_mem_pkg;

    typedef enum logic [1:0] {
        OP_PASS  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_e;

    function automatic op_e classify(input logic mem_en, input logic mem_rw);
        if (!mem_en)
            return OP_PASS;
        return mem_rw ? OP_STORE : OP_LOAD;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous data RAM, write-first, registered read data.
// Contents and read register hold whenever en is low.
module dm_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_stage.sv
// MIPS memory stage: valid/ready handshake, load/store/pass against dm_ram,
// one-cycle registered result, range check and saturating debug counters.
module data_mem_stage
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] dm_data,
    input  logic              mem_en_ex,
    input  logic              mem_rw_ex,
    input  logic              mem_mux_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ans_dm,
    output logic              addr_err,
    output logic [CNT_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  store_cnt
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] addr;
    logic              in_range;
    logic              accept;
    logic              ram_en;
    op_e               op;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] ans_q;
    logic              use_mem_q;

    assign addr     = ans_ex[ADDR_W-1:0];
    assign in_range = 32'(addr) < 32'(DEPTH);
    assign op       = classify(mem_en_ex, mem_rw_ex);
    assign in_ready = !out_valid || out_ready;
    // Transactions seen while reset is high must not touch RAM or counters.
    assign accept   = in_valid && in_ready && !reset;
    assign ram_en   = accept && in_range && (op != OP_PASS);

    dm_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (op == OP_STORE),
        .addr  (addr[RAM_AW-1:0]),
        .wdata (dm_data),
        .rdata (rd_data)
    );

    // Out-of-range accesses never reach the RAM, so their data is forced to 0.
    assign ans_dm = use_mem_q ? (addr_err ? {DATA_W{1'b0}} : rd_data) : ans_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            ans_q     <= '0;
            use_mem_q <= 1'b0;
            addr_err  <= 1'b0;
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                ans_q     <= ans_ex;
                use_mem_q <= mem_mux_sel && mem_en_ex;
                addr_err  <= mem_en_ex && !in_range;
                if (in_range && op == OP_LOAD && load_cnt != {CNT_W{1'b1}})
                    load_cnt <= load_cnt + 1'b1;
                if (in_range && op == OP_STORE && store_cnt != {CNT_W{1'b1}})
                    store_cnt <= store_cnt + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage with DEPTH=200 and CNT_W=2 so range and
// saturation corners are reachable with short vectors.
module tb_data_mem_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready;
    logic [7:0] ans_ex, dm_data;
    logic       mem_en_ex, mem_rw_ex, mem_mux_sel;
    logic       out_valid, out_ready, addr_err;
    logic [7:0] ans_dm;
    logic [1:0] load_cnt, store_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    data_mem_stage #(
        .DATA_W (8),
        .ADDR_W (8),
        .DEPTH  (200),
        .CNT_W  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ans_ex      (ans_ex),
        .dm_data     (dm_data),
        .mem_en_ex   (mem_en_ex),
        .mem_rw_ex   (mem_rw_ex),
        .mem_mux_sel (mem_mux_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ans_dm      (ans_dm),
        .addr_err    (addr_err),
        .load_cnt    (load_cnt),
        .store_cnt   (store_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, return 1 ns after the next rising edge.
    task automatic step(input logic vld, input logic en, input logic rw, input logic sel,
                        input logic [7:0] a, input logic [7:0] d, input logic rdy);
        @(negedge clk);
        in_valid    = vld;
        mem_en_ex   = en;
        mem_rw_ex   = rw;
        mem_mux_sel = sel;
        ans_ex      = a;
        dm_data     = d;
        out_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; mem_en_ex = 1'b0; mem_rw_ex = 1'b0; mem_mux_sel = 1'b0;
        ans_ex = '0; dm_data = '0; out_ready = 1'b1;
        step(0, 0, 0, 0, 8'h00, 8'h00, 1);
        step(1, 1, 1, 0, 8'h10, 8'hEE, 1);   // must be ignored under reset
        @(negedge clk) reset = 1'b0;

        // Mid-cycle reset drops a freshly accepted result.
        step(1, 0, 0, 0, 8'h77, 8'h00, 1);
        check("pass_pre_reset", ans_dm, 8'h77);
        #2 reset = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_ans_dm", ans_dm, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_counts", {load_cnt, store_cnt}, 0);
        @(negedge clk) reset = 1'b0;
        #1 check("rst_in_ready", in_ready, 1);

        // Store then back-to-back load of the same address.
        step(1, 1, 1, 0, 8'h10, 8'h5A, 1);
        check("st_valid", out_valid, 1);
        check("st_ans_alu", ans_dm, 8'h10);
        check("st_cnt", store_cnt, 1);
        step(1, 1, 0, 1, 8'h10, 8'h00, 1);
        check("ld_data", ans_dm, 8'h5A);
        check("ld_err", addr_err, 0);
        check("ld_cnt", load_cnt, 1);

        // Pass-through ignores mux select when memory is disabled.
        step(1, 0, 1, 1, 8'h33, 8'h99, 1);
        check("pass_data", ans_dm, 8'h33);
        check("pass_counts", {load_cnt, store_cnt}, 4'b0101);
        step(0, 0, 0, 0, 8'h00, 8'h00, 1);
        check("drain_valid", out_valid, 0);

        // Stall: pending 0x44 held while a load waits.
        step(1, 0, 0, 0, 8'h44, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1, 8'h10, 8'h00, 0);
            check("stall_ready", in_ready, 0);
            check("stall_data", ans_dm, 8'h44);
            check("stall_valid", out_valid, 1);
        end
        check("stall_ld_cnt", load_cnt, 1);
        step(1, 1, 0, 1, 8'h10, 8'h00, 1);
        check("unstall_valid", out_valid, 1);
        check("unstall_data", ans_dm, 8'h5A);
        check("unstall_cnt", load_cnt, 2);

        // Range boundary at DEPTH=200.
        step(1, 1, 1, 0, 8'hC8, 8'hFF, 1);
        check("oor_st_err", addr_err, 1);
        check("oor_st_cnt", store_cnt, 1);
        step(1, 1, 0, 1, 8'hC8, 8'h00, 1);
        check("oor_ld_data", ans_dm, 0);
        check("oor_ld_err", addr_err, 1);
        check("oor_ld_cnt", load_cnt, 2);
        step(1, 1, 1, 0, 8'hC7, 8'h12, 1);
        check("top_st_cnt", store_cnt, 2);
        step(1, 1, 0, 1, 8'hC7, 8'h00, 1);
        check("top_ld_err", addr_err, 0);
        check("top_ld_data", ans_dm, 8'h12);
        check("top_ld_cnt", load_cnt, 3);

        // Saturation of 2-bit load counter.
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 1, 8'h10, 8'h00, 1);
            check("sat_ld_cnt", load_cnt, 3);
        end

        // Reset while a result is stalled; RAM contents survive.
        step(1, 0, 0, 0, 8'h66, 8'h00, 1);
        step(0, 0, 0, 0, 8'h00, 8'h00, 0);
        check("stall2_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1 check("stall2_rst_valid", out_valid, 0);
        @(negedge clk) reset = 1'b0;
        step(1, 1, 0, 1, 8'h10, 8'h00, 1);
        check("post_rst_data", ans_dm, 8'h5A);
        check("post_rst_cnt", {load_cnt, store_cnt}, 4'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
